// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the pipe_reg_chain pipeline register family.
package pipe_reg_pkg;

  // Smallest legal number of register stages in a chain.
  localparam int MIN_STAGES = 32'sd1;

  // Width of a counter able to hold the values 0..stages.
  function automatic int occ_w(input int stages);
    return $clog2(stages + 32'sd1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline slot: a valid bit plus a WIDTH-bit data register with a
// valid/ready handshake on both sides. The slot accepts a new word when it is
// empty or when its current word leaves this cycle, which is what lets empty
// slots swallow bubbles while the output stalls.
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = 32'sd32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             take_s;

  // Ready is combinational so a whole stalled chain can shift in one cycle.
  assign up_ready = ~valid_r | dn_ready;
  assign take_s   = up_valid & up_ready;
  assign dn_valid = valid_r;
  assign dn_data  = data_r;

  // Valid bit: flush wins, then capture, then drain when the word moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (take_s) begin
      valid_r <= 1'b1;
    end else if (up_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data register: loads only on an accepted transfer, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {WIDTH{1'b0}};
    end else if (take_s && !flush) begin
      data_r <= up_data;
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Multi-stage valid/ready pipeline register with bubble collapsing,
// back-pressure and a synchronous flush. Words leave in strict FIFO order.
// Optional feature macro: PIPE_REG_OCC_EN adds a registered occupancy count.
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH  = 32'sd32,
  parameter int STAGES = 32'sd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [occ_w(STAGES)-1:0] occupancy
`endif
);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("pipe_reg_chain: STAGES must be at least %0d", MIN_STAGES);
  end

  // valid_s[i]/data_s[i] feed stage i; index STAGES is the chain output.
  logic [STAGES:0]  valid_s;
  logic [WIDTH-1:0] data_s [STAGES+1];

  // A flushing cycle never offers the producer word to stage 0.
  assign valid_s[0] = in_valid & ~flush;
  assign data_s[0]  = in_data;

  for (genvar i = 0; i < STAGES; i++) begin : gen_stage
    logic up_rdy_s;
    logic dn_rdy_s;

    // Each stage's downstream ready is the next stage's ready, or the consumer.
    if (i == STAGES - 1) begin : g_last
      assign dn_rdy_s = out_ready;
    end else begin : g_inner
      assign dn_rdy_s = gen_stage[i + 1].up_rdy_s;
    end

    pipe_reg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (valid_s[i]),
      .up_ready (up_rdy_s),
      .up_data  (data_s[i]),
      .dn_valid (valid_s[i+1]),
      .dn_ready (dn_rdy_s),
      .dn_data  (data_s[i+1])
    );
  end

  assign in_ready  = gen_stage[0].up_rdy_s & ~flush;
  assign out_valid = valid_s[STAGES];
  assign out_data  = data_s[STAGES];

`ifdef PIPE_REG_OCC_EN
  localparam int OCC_W = occ_w(STAGES);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(32'd1);

  logic             enq_s;
  logic             deq_s;
  logic [OCC_W-1:0] occ_r;

  assign enq_s     = in_valid & in_ready;
  assign deq_s     = out_valid & out_ready;
  assign occupancy = occ_r;

  // Word count: a simultaneous enqueue and dequeue leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (enq_s && !deq_s) begin
      occ_r <= occ_r + OCC_ONE;
    end else if (deq_s && !enq_s) begin
      occ_r <= occ_r - OCC_ONE;
    end else begin
      occ_r <= occ_r;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: three instances (2, 3 and 4 stages),
// directed vector tables, hand-written corner sequences and a randomized run
// against a queue-based reference model.
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  int          sel;

  logic        iv2, iv3, iv4;
  logic        ir2, ir3, ir4;
  logic        ov2, ov3, ov4;
  logic [31:0] od2, od3;
  logic [7:0]  od4;
`ifdef PIPE_REG_OCC_EN
  logic [1:0]  oc2, oc3;
  logic [2:0]  oc4;
  int          act_occ;
`endif

  assign iv2 = in_valid && (sel == 2);
  assign iv3 = in_valid && (sel == 3);
  assign iv4 = in_valid && (sel == 4);

  pipe_reg_chain #(.WIDTH(32), .STAGES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv2), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2)
`ifdef PIPE_REG_OCC_EN
    , .occupancy(oc2)
`endif
  );

  pipe_reg_chain #(.WIDTH(32), .STAGES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv3), .in_ready(ir3),
    .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3)
`ifdef PIPE_REG_OCC_EN
    , .occupancy(oc3)
`endif
  );

  pipe_reg_chain #(.WIDTH(8), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv4), .in_ready(ir4),
    .in_data(in_data[7:0]), .out_valid(ov4), .out_ready(out_ready), .out_data(od4)
`ifdef PIPE_REG_OCC_EN
    , .occupancy(oc4)
`endif
  );

  logic        act_ir, act_ov;
  logic [31:0] act_od;

  always_comb begin
    act_ir = ir4;
    act_ov = ov4;
    act_od = {24'h0, od4};
`ifdef PIPE_REG_OCC_EN
    act_occ = int'(oc4);
`endif
    case (sel)
      2: begin
        act_ir = ir2; act_ov = ov2; act_od = od2;
`ifdef PIPE_REG_OCC_EN
        act_occ = int'(oc2);
`endif
      end
      3: begin
        act_ir = ir3; act_ov = ov3; act_od = od3;
`ifdef PIPE_REG_OCC_EN
        act_occ = int'(oc3);
`endif
      end
      default: ;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_occ(input string name, input int exp);
`ifdef PIPE_REG_OCC_EN
    chk(name, act_occ, exp);
`endif
  endtask

  // Drive one cycle of inputs, compare outputs at the falling edge, advance.
  task automatic cycle_chk(input string tag, input bit iv, input logic [31:0] d,
                           input bit ordy, input bit fl, input bit e_ir,
                           input bit e_ov, input logic [31:0] e_od, input int e_occ);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'b0, act_ir}, {31'b0, e_ir});
    chk({tag, " out_valid"}, {31'b0, act_ov}, {31'b0, e_ov});
    if (e_ov) chk({tag, " out_data"}, act_od, e_od);
    chk_occ({tag, " occupancy"}, e_occ);
    @(posedge clk); #1;
  endtask

  task automatic reset_pipes();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 32'h0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit iv; logic [31:0] d; bit ordy; bit fl;
    bit e_ir; bit e_ov; logic [31:0] e_od; int e_occ;
  } vec_t;
  vec_t tbl[$];

  task automatic run_table(input string name);
    foreach (tbl[k])
      cycle_chk($sformatf("%s c%0d", name, k), tbl[k].iv, tbl[k].d, tbl[k].ordy,
                tbl[k].fl, tbl[k].e_ir, tbl[k].e_ov, tbl[k].e_od, tbl[k].e_occ);
  endtask

  // Reference model: a FIFO of words, each with its slot index 0..s-1.
  // Words slide toward slot s-1 each cycle unless the word ahead stays put.
  typedef struct { logic [31:0] d; int pos; } word_t;
  word_t q[$];

  function automatic bit mdl_in_ready(input bit ordy, input bit fl, input int s);
    return !fl && ((q.size() < s) || ordy);
  endfunction

  function automatic void mdl_advance(input bit iv, input logic [31:0] d,
                                      input bit ordy, input bit fl, input int s);
    word_t nq[$];
    word_t w;
    int    lim;
    bit    acc;
    acc = iv && mdl_in_ready(ordy, fl, s);
    if (fl) begin
      q.delete();
    end else begin
      lim = ordy ? s : s - 1;
      foreach (q[k]) begin
        w = q[k];
        w.pos = (w.pos + 1 < lim) ? w.pos + 1 : lim;
        lim = w.pos - 1;
        if (w.pos < s) nq.push_back(w);
      end
      if (acc) nq.push_back('{d, 0});
      q = nq;
    end
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = 32'hDEAD_BEEF; sel = 2;

    // 1: reset held with in_valid=1 on every instance
    repeat (3) @(posedge clk);
    #1;
    for (int s = 2; s <= 4; s++) begin
      sel = s; #1;
      chk($sformatf("reset s%0d out_valid", s), {31'b0, act_ov}, 32'h0);
      chk($sformatf("reset s%0d out_data", s), act_od, 32'h0);
      chk_occ($sformatf("reset s%0d occupancy", s), 0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int s = 2; s <= 4; s++) begin
      sel = s; #1;
      chk($sformatf("release s%0d in_ready", s), {31'b0, act_ir}, 32'h1);
    end
    @(posedge clk); #1;

    // 2: back-to-back stream through two stages
    sel = 2; reset_pipes();
    tbl.delete();
    for (int c = 0; c <= 10; c++)
      tbl.push_back('{(c < 8), 32'(c + 1), 1'b1, 1'b0, 1'b1,
                      (c >= 2 && c <= 9), 32'(c - 1),
                      (c == 0) ? 0 : (c == 1) ? 1 : (c <= 8) ? 2 : (c == 9) ? 1 : 0});
    run_table("stream");

    // 3: fill under stall, then drain in order
    sel = 2; reset_pipes();
    tbl.delete();
    tbl.push_back('{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0});
    tbl.push_back('{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1});
    tbl.push_back('{1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 2});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA, 2});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB, 1});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0});
    run_table("stall");

    // 4: bubble collapse in three stages; 0x44 must be refused when full
    sel = 3; reset_pipes();
    cycle_chk("bubble c0", 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0);
    cycle_chk("bubble c1", 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    cycle_chk("bubble c2", 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    cycle_chk("bubble c3", 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1);
    cycle_chk("bubble c4", 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 2);
    cycle_chk("bubble c5", 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 3);
    cycle_chk("bubble c6", 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 3);
    cycle_chk("bubble c7", 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 2);
    cycle_chk("bubble c8", 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 1);
    cycle_chk("bubble c9", 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0);

    // 5: flush of a full pipe, with and without an output handshake
    sel = 2; reset_pipes();
    cycle_chk("flush c0",  1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0);
    cycle_chk("flush c1",  1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    cycle_chk("flush c2",  1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA1, 2);
    cycle_chk("flush c3",  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0);
    cycle_chk("flush c4",  1'b1, 32'hB1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0);
    cycle_chk("flush c5",  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    cycle_chk("flush c6",  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB1, 1);
    cycle_chk("flush c7",  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0);
    cycle_chk("flush c8",  1'b1, 32'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0);
    cycle_chk("flush c9",  1'b1, 32'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    cycle_chk("flush c10", 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'hC1, 2);
    cycle_chk("flush c11", 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0);

    // 6: random traffic on the 4-stage, 8-bit instance against the model
    sel = 4; reset_pipes();
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) begin
        in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        #2; rst_n = 1'b0; #1;
        chk("rand async reset out_valid", {31'b0, act_ov}, 32'h0);
        chk("rand async reset out_data", act_od, 32'h0);
        chk_occ("rand async reset occupancy", 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom_range(0, 255);
      out_ready = (((c / 700) % 2) == 0) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      chk($sformatf("rand c%0d in_ready", c), {31'b0, act_ir},
          {31'b0, mdl_in_ready(out_ready, flush, 4)});
      chk($sformatf("rand c%0d out_valid", c), {31'b0, act_ov},
          {31'b0, (q.size() > 0 && q[0].pos == 3)});
      if (q.size() > 0 && q[0].pos == 3)
        chk($sformatf("rand c%0d out_data", c), act_od, q[0].d);
      chk_occ($sformatf("rand c%0d occupancy", c), q.size());
      mdl_advance(in_valid, in_data, out_ready, flush, 4);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
